// File: rtl/debug_host_driver.sv
// debug_host_driver
//   Host-side initiator for the pipeline debug UART protocol. Sends the
//   command byte streams a PC debugger would send into a UART TX FIFO:
//   program load, run-to-halt, single step and end debug. It then parses the
//   returned 65-word state frame from the UART RX FIFO onto a dump port.
//   The frame holds 32 registers, 32 data-memory words and the PC.
//
//   Ports
//     i_clk, i_reset      clock, async active-high reset
//     i_start/i_cmd       command request (00 LOAD, 01 RUN, 10 STEP, 11 END)
//     i_prog_size         instruction count for LOAD
//     o_rom_addr          program ROM word address
//     i_rom_data          ROM data, valid one cycle after the address changes
//     o_tx_data/o_wr      TX FIFO byte and write strobe
//     i_tx_full           TX FIFO full
//     i_rx_data/o_rd      RX FIFO head (show-ahead) and pop strobe
//     i_rx_empty          RX FIFO empty
//     o_dump_*            assembled frame word, index 0..64
//     o_busy/o_done       command in progress / one-cycle completion pulse
//     o_error             sticky RX timeout flag
//     o_session           debug (step) session open
module debug_host_driver #(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 1_000_000
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic [1:0]        i_cmd,
  input  logic [ADDR_W-1:0] i_prog_size,
  output logic [ADDR_W-1:0] o_rom_addr,
  input  logic [31:0]       i_rom_data,
  output logic [7:0]        o_tx_data,
  output logic              o_wr,
  input  logic              i_tx_full,
  input  logic [7:0]        i_rx_data,
  output logic              o_rd,
  input  logic              i_rx_empty,
  output logic              o_dump_we,
  output logic [6:0]        o_dump_addr,
  output logic [31:0]       o_dump_data,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_error,
  output logic              o_session
);

  localparam int TO_W = $clog2(TIMEOUT + 1);

  localparam logic [1:0] CMD_LOAD = 2'b00;
  localparam logic [1:0] CMD_RUN  = 2'b01;
  localparam logic [1:0] CMD_STEP = 2'b10;
  localparam logic [1:0] CMD_END  = 2'b11;

  localparam logic [7:0] B_LOAD  = 8'hFE;
  localparam logic [7:0] B_RUN   = 8'hF0;
  localparam logic [7:0] B_DEBUG = 8'hFC;
  localparam logic [7:0] B_NEXT  = 8'h01;
  localparam logic [7:0] B_END   = 8'hF8;

  typedef enum logic [2:0] {
    S_IDLE, S_TX_CMD, S_TX_SIZE, S_ROM_FETCH,
    S_TX_INST, S_TX_NEXT, S_RX_FRAME, S_FINISH
  } state_t;

  state_t            r_state, w_next;
  logic [1:0]        r_cmd;
  logic [ADDR_W-1:0] r_size;
  logic [ADDR_W-1:0] r_rom_addr;
  logic [1:0]        r_byte_idx;   // byte within instruction (TX) or word (RX)
  logic [6:0]        r_word_idx;
  logic [23:0]       r_rx_word;    // first three bytes of the word in flight
  logic [TO_W-1:0]   r_to_cnt;
  logic              r_session, r_error;
  logic              r_dump_we;
  logic [6:0]        r_dump_addr;
  logic [31:0]       r_dump_data;

  logic              w_tx_req, w_tx_ok, w_pop, w_word_done, w_last_word;
  logic              w_timeout, w_rx_enter;
  logic [7:0]        w_tx_byte, w_rom_byte;
  logic [ADDR_W-1:0] w_rom_next;

  assign w_tx_ok     = !i_tx_full;
  assign w_pop       = (r_state == S_RX_FRAME) && !i_rx_empty;
  assign w_word_done = w_pop && (r_byte_idx == 2'd3);
  assign w_last_word = (r_word_idx == 7'd64);
  assign w_timeout   = (r_state == S_RX_FRAME) && i_rx_empty &&
                       (r_to_cnt == TO_W'(TIMEOUT - 1));
  assign w_rx_enter  = (w_next == S_RX_FRAME) && (r_state != S_RX_FRAME);
  assign w_rom_next  = r_rom_addr + 1'b1;

  always_comb begin
    w_rom_byte = i_rom_data[7:0];
    case (r_byte_idx)
      2'd0: w_rom_byte = i_rom_data[7:0];
      2'd1: w_rom_byte = i_rom_data[15:8];
      2'd2: w_rom_byte = i_rom_data[23:16];
      2'd3: w_rom_byte = i_rom_data[31:24];
      default: w_rom_byte = i_rom_data[7:0];
    endcase
  end

  always_comb begin
    w_next    = r_state;
    w_tx_req  = 1'b0;
    w_tx_byte = 8'h00;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          // Empty LOAD, END outside a session and STEP inside an open
          // session all skip the command byte.
          if (i_cmd == CMD_LOAD && i_prog_size == '0)   w_next = S_FINISH;
          else if (i_cmd == CMD_END && !r_session)      w_next = S_FINISH;
          else if (i_cmd == CMD_STEP && r_session)      w_next = S_TX_NEXT;
          else                                          w_next = S_TX_CMD;
        end
      end
      S_TX_CMD: begin
        w_tx_req = 1'b1;
        case (r_cmd)
          CMD_LOAD: w_tx_byte = B_LOAD;
          CMD_RUN:  w_tx_byte = B_RUN;
          CMD_STEP: w_tx_byte = B_DEBUG;
          default:  w_tx_byte = B_END;
        endcase
        if (w_tx_ok) begin
          case (r_cmd)
            CMD_LOAD: w_next = S_TX_SIZE;
            CMD_RUN:  w_next = S_RX_FRAME;
            CMD_STEP: w_next = S_TX_NEXT;
            default:  w_next = S_FINISH;
          endcase
        end
      end
      S_TX_SIZE: begin
        w_tx_req  = 1'b1;
        w_tx_byte = r_size[7:0];
        if (w_tx_ok) w_next = S_ROM_FETCH;
      end
      S_ROM_FETCH: w_next = S_TX_INST;
      S_TX_INST: begin
        w_tx_req  = 1'b1;
        w_tx_byte = w_rom_byte;
        if (w_tx_ok && r_byte_idx == 2'd3)
          w_next = (w_rom_next == r_size) ? S_FINISH : S_ROM_FETCH;
      end
      S_TX_NEXT: begin
        w_tx_req  = 1'b1;
        w_tx_byte = B_NEXT;
        if (w_tx_ok) w_next = S_RX_FRAME;
      end
      S_RX_FRAME: begin
        if (w_word_done && w_last_word) w_next = S_FINISH;
        else if (w_timeout)             w_next = S_FINISH;
      end
      S_FINISH: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_cmd       <= CMD_LOAD;
      r_size      <= '0;
      r_rom_addr  <= '0;
      r_byte_idx  <= 2'd0;
      r_word_idx  <= 7'd0;
      r_rx_word   <= 24'h0;
      r_to_cnt    <= '0;
      r_session   <= 1'b0;
      r_error     <= 1'b0;
      r_dump_we   <= 1'b0;
      r_dump_addr <= 7'd0;
      r_dump_data <= 32'h0;
    end else begin
      r_state   <= w_next;
      r_dump_we <= 1'b0;

      if (r_state == S_IDLE && i_start) begin
        r_cmd   <= i_cmd;
        r_size  <= i_prog_size;
        r_error <= 1'b0;
      end

      if (r_state == S_TX_CMD && w_tx_ok) begin
        if (r_cmd == CMD_STEP) r_session <= 1'b1;
        if (r_cmd == CMD_END)  r_session <= 1'b0;
      end

      if (r_state == S_TX_SIZE && w_tx_ok) begin
        r_rom_addr <= '0;
        r_byte_idx <= 2'd0;
      end

      if (r_state == S_TX_INST && w_tx_ok) begin
        r_byte_idx <= r_byte_idx + 2'd1;
        if (r_byte_idx == 2'd3) r_rom_addr <= w_rom_next;
      end

      if (w_rx_enter) begin
        r_byte_idx <= 2'd0;
        r_word_idx <= 7'd0;
        r_to_cnt   <= '0;
      end else if (r_state == S_RX_FRAME) begin
        if (w_pop) begin
          r_to_cnt   <= '0;
          r_byte_idx <= r_byte_idx + 2'd1;
          r_rx_word  <= {i_rx_data, r_rx_word[23:8]};
          if (w_word_done) begin
            r_dump_we   <= 1'b1;
            r_dump_addr <= r_word_idx;
            r_dump_data <= {i_rx_data, r_rx_word};
            r_word_idx  <= r_word_idx + 7'd1;
            if (w_last_word && r_cmd == CMD_RUN) r_session <= 1'b0;
          end
        end else if (w_timeout) begin
          r_error   <= 1'b1;
          r_session <= 1'b0;
        end else begin
          r_to_cnt <= r_to_cnt + 1'b1;
        end
      end
    end
  end

  assign o_rom_addr  = r_rom_addr;
  assign o_tx_data   = w_tx_byte;
  assign o_wr        = w_tx_req && w_tx_ok;
  assign o_rd        = w_pop;
  assign o_dump_we   = r_dump_we;
  assign o_dump_addr = r_dump_addr;
  assign o_dump_data = r_dump_data;
  assign o_busy      = (r_state != S_IDLE);
  assign o_done      = (r_state == S_FINISH);
  assign o_error     = r_error;
  assign o_session   = r_session;

endmodule

// File: tb/tb_debug_host_driver.sv
module tb_debug_host_driver;
  localparam int ADDR_W  = 8;
  localparam int TIMEOUT = 64;

  logic              i_clk = 1'b0;
  logic              i_reset = 1'b1;
  logic              i_start = 1'b0;
  logic [1:0]        i_cmd = 2'b00;
  logic [ADDR_W-1:0] i_prog_size = '0;
  logic [ADDR_W-1:0] o_rom_addr;
  logic [31:0]       i_rom_data = 32'h0;
  logic [7:0]        o_tx_data;
  logic              o_wr;
  logic              i_tx_full = 1'b0;
  logic [7:0]        i_rx_data = 8'h0;
  logic              o_rd;
  logic              i_rx_empty = 1'b1;
  logic              o_dump_we;
  logic [6:0]        o_dump_addr;
  logic [31:0]       o_dump_data;
  logic              o_busy, o_done, o_error, o_session;

  debug_host_driver #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start), .i_cmd(i_cmd),
    .i_prog_size(i_prog_size), .o_rom_addr(o_rom_addr), .i_rom_data(i_rom_data),
    .o_tx_data(o_tx_data), .o_wr(o_wr), .i_tx_full(i_tx_full),
    .i_rx_data(i_rx_data), .o_rd(o_rd), .i_rx_empty(i_rx_empty),
    .o_dump_we(o_dump_we), .o_dump_addr(o_dump_addr), .o_dump_data(o_dump_data),
    .o_busy(o_busy), .o_done(o_done), .o_error(o_error), .o_session(o_session)
  );

  always #5 i_clk = ~i_clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- monitors (sampled at negedge) ----------------
  logic [7:0]  tx_log[$];
  logic [38:0] dump_log[$];
  int done_cnt, rd_cnt, busy_cnt, wr_full_cnt, cyc, last_rd_cyc, err_cyc;
  logic err_prev = 1'b0;
  logic rd_seen  = 1'b0;

  always @(negedge i_clk) begin
    cyc++;
    if (o_wr) tx_log.push_back(o_tx_data);
    if (o_wr && i_tx_full) wr_full_cnt++;
    if (o_dump_we) dump_log.push_back({o_dump_addr, o_dump_data});
    if (o_done) done_cnt++;
    if (o_rd) begin rd_cnt++; last_rd_cyc = cyc; end
    if (o_busy) busy_cnt++;
    if (o_error && !err_prev) err_cyc = cyc;
    err_prev = o_error;
    rd_seen  = o_rd;
  end

  // ---------------- synchronous program ROM ----------------
  logic [31:0] rom [256];
  logic [7:0]  rom_addr_q = 8'h0;
  always @(negedge i_clk) rom_addr_q = o_rom_addr;
  always @(posedge i_clk) begin #1; i_rom_data = rom[rom_addr_q]; end

  // ---------------- TX FIFO back-pressure ----------------
  int full_mode = 0;  // 0 never full, 1 toggles, 2 random
  always @(posedge i_clk) begin
    #1;
    case (full_mode)
      0:       i_tx_full = 1'b0;
      1:       i_tx_full = ~i_tx_full;
      default: i_tx_full = ($urandom_range(0, 2) == 0);
    endcase
  end

  // ---------------- RX responder: byte queue with random gaps ----------------
  logic [7:0] rx_q[$];
  int gap_max = 0;
  int gap_left = 0;
  always @(posedge i_clk) begin
    #1;
    if (rd_seen && rx_q.size() > 0) begin
      rx_q.delete(0);
      gap_left = $urandom_range(0, gap_max);
      rd_seen  = 1'b0;
    end else if (gap_left > 0) begin
      gap_left--;
    end
    i_rx_empty = (rx_q.size() == 0) || (gap_left > 0);
    i_rx_data  = (rx_q.size() > 0) ? rx_q[0] : 8'h00;
  end

  // ---------------- reference model ----------------
  logic [7:0]  exp_tx[$];
  logic [31:0] frame_w [65];
  logic        m_session = 1'b0;

  task automatic build_load(input int size);
    exp_tx.delete();
    if (size == 0) return;
    exp_tx.push_back(8'hFE);
    exp_tx.push_back(8'(size));
    for (int k = 0; k < size; k++)
      for (int b = 0; b < 4; b++) exp_tx.push_back(rom[k][8*b +: 8]);
  endtask

  task automatic load_frame(input bit patterned, input int nbytes);
    rx_q.delete();
    for (int i = 0; i < 65; i++) begin
      if (!patterned)  frame_w[i] = $urandom;
      else if (i < 32) frame_w[i] = 32'(i);
      else if (i < 64) frame_w[i] = 32'h100 + 32'(i - 32);
      else             frame_w[i] = 32'h40;
    end
    for (int i = 0; i < 65; i++)
      for (int b = 0; b < 4; b++)
        if (rx_q.size() < nbytes) rx_q.push_back(frame_w[i][8*b +: 8]);
  endtask

  task automatic chk_tx(input string tag);
    chk({tag, " tx_len"}, 64'(tx_log.size()), 64'(exp_tx.size()));
    for (int i = 0; i < exp_tx.size() && i < tx_log.size(); i++)
      chk($sformatf("%s tx[%0d]", tag, i), 64'(tx_log[i]), 64'(exp_tx[i]));
  endtask

  task automatic chk_dumps(input string tag, input int n);
    chk({tag, " dump_cnt"}, 64'(dump_log.size()), 64'(n));
    for (int i = 0; i < n && i < dump_log.size(); i++)
      chk($sformatf("%s dump[%0d]", tag, i), 64'(dump_log[i]), 64'({7'(i), frame_w[i]}));
  endtask

  task automatic chk_reset(input string tag);
    chk(tag, 64'({o_tx_data, o_wr, o_rd, o_rom_addr, o_dump_we, o_dump_addr,
                  o_dump_data, o_busy, o_done, o_error, o_session}), 64'h0);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] cmd, input int size);
    tx_log.delete(); dump_log.delete();
    done_cnt = 0; rd_cnt = 0; busy_cnt = 0; wr_full_cnt = 0; err_cyc = 0;
    i_start = 1'b1; i_cmd = cmd; i_prog_size = 8'(size);
    @(posedge i_clk); #1;
    i_start = 1'b0;
  endtask

  // Waits for o_done; optionally raises i_start during the o_done cycle.
  task automatic wait_done(input string tag, input bit poke);
    int n = 0;
    do begin @(negedge i_clk); n++; end while (!o_done && n < 20000);
    chk({tag, " done_timeout"}, 64'(n >= 20000), 64'h0);
    if (poke) begin
      i_start = 1'b1; i_cmd = 2'b00; i_prog_size = 8'd1;
      @(posedge i_clk); #1;
      i_start = 1'b0;
    end
    tick(2);
  endtask

  // STEP model: command byte only when no session is open.
  task automatic run_step(input string tag, input bit patterned, input int gmax);
    load_frame(patterned, 260);
    gap_max = gmax;
    exp_tx.delete();
    if (!m_session) exp_tx.push_back(8'hFC);
    exp_tx.push_back(8'h01);
    m_session = 1'b1;
    issue(2'b10, 0);
    wait_done(tag, 1'b0);
    chk_tx(tag);
    chk_dumps(tag, 65);
    chk({tag, " rd_cnt"}, 64'(rd_cnt), 64'd260);
    chk({tag, " session"}, 64'(o_session), 64'(m_session));
    chk({tag, " done_cnt"}, 64'(done_cnt), 64'd1);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 32'h0;
    #2;
    chk_reset("reset_vals");
    tick(3);
    i_reset = 1'b0;
    tick(2);
    chk_reset("post_reset_idle");

    // LOAD size 2, TX never full, with latency and cycle-count checks
    full_mode = 0;
    rom[0] = 32'h11223344; rom[1] = 32'hAABBCCDD;
    build_load(2);
    issue(2'b00, 2);
    chk("load1 busy_first", 64'(o_busy), 64'h1);
    chk("load1 first_wr", 64'({o_wr, o_tx_data}), 64'({1'b1, 8'hFE}));
    wait_done("load1", 1'b0);
    chk_tx("load1");
    chk("load1 busy_cycles", 64'(busy_cnt), 64'(2 + 5*2 + 1));
    chk("load1 done_cnt", 64'(done_cnt), 64'd1);
    chk("load1 rd_cnt", 64'(rd_cnt), 64'd0);

    // LOAD size 5 with TX full toggling
    for (int i = 0; i < 5; i++) rom[i] = $urandom;
    full_mode = 1;
    build_load(5);
    issue(2'b00, 5);
    wait_done("load2", 1'b0);
    chk_tx("load2");
    chk("load2 wr_while_full", 64'(wr_full_cnt), 64'd0);
    chk("load2 done_cnt", 64'(done_cnt), 64'd1);

    // STEP twice then END
    full_mode = 0;
    run_step("step1", 1'b1, 0);
    full_mode = 2;
    run_step("step2", 1'b0, 10);

    exp_tx.delete(); exp_tx.push_back(8'hF8); m_session = 1'b0;
    issue(2'b11, 0);
    wait_done("end1", 1'b0);
    chk_tx("end1");
    chk("end1 session", 64'(o_session), 64'h0);
    chk("end1 dumps", 64'(dump_log.size()), 64'd0);

    // END with no session: straight to FINISH
    exp_tx.delete();
    issue(2'b11, 0);
    wait_done("end2", 1'b0);
    chk_tx("end2");
    chk("end2 busy_cycles", 64'(busy_cnt), 64'd1);
    chk("end2 done_cnt", 64'(done_cnt), 64'd1);

    // RUN inside a session with random RX gaps and random back-pressure
    run_step("step3", 1'b0, 3);
    load_frame(1'b0, 260);
    gap_max = 12;
    exp_tx.delete(); exp_tx.push_back(8'hF0);
    issue(2'b01, 0);
    wait_done("run1", 1'b0);
    m_session = 1'b0;
    chk_tx("run1");
    chk_dumps("run1", 65);
    chk("run1 error", 64'(o_error), 64'h0);
    chk("run1 session", 64'(o_session), 64'h0);
    chk("run1 done_cnt", 64'(done_cnt), 64'd1);

    // RUN with frame cut after 100 bytes; i_start during o_done is ignored
    full_mode = 0;
    run_step("step4", 1'b1, 2);
    load_frame(1'b0, 100);
    gap_max = 5;
    exp_tx.delete(); exp_tx.push_back(8'hF0);
    issue(2'b01, 0);
    wait_done("run2", 1'b1);
    m_session = 1'b0;
    chk_tx("run2");
    chk_dumps("run2", 25);
    chk("run2 error", 64'(o_error), 64'h1);
    chk("run2 session", 64'(o_session), 64'h0);
    chk("run2 done_cnt", 64'(done_cnt), 64'd1);
    chk("run2 timeout_latency", 64'(err_cyc - last_rd_cyc), 64'(TIMEOUT + 1));
    chk("run2 start_in_done_ignored", 64'(o_busy), 64'h0);

    // Next accepted i_start clears o_error
    for (int i = 0; i < 3; i++) rom[i] = $urandom;
    build_load(3);
    issue(2'b00, 3);
    chk("load3 error_cleared", 64'(o_error), 64'h0);
    wait_done("load3", 1'b0);
    chk_tx("load3");

    // Async reset in the 3rd instruction of a LOAD, with a session open
    run_step("step5", 1'b1, 0);
    for (int i = 0; i < 4; i++) rom[i] = $urandom;
    issue(2'b00, 4);
    begin
      int n = 0;
      while (tx_log.size() < 11 && n < 1000) begin tick(1); n++; end
      chk("rst wait_timeout", 64'(n >= 1000), 64'h0);
    end
    i_reset = 1'b1;
    #1;
    chk_reset("rst mid_load");
    tick(2);
    i_reset = 1'b0;
    m_session = 1'b0;
    tick(2);
    chk_reset("rst released_idle");

    rom[0] = 32'hCAFEF00D; rom[1] = 32'h0BADBEEF;
    build_load(2);
    issue(2'b00, 2);
    wait_done("load4", 1'b0);
    chk_tx("load4");
    chk("load4 done_cnt", 64'(done_cnt), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/debug_host_driver.md
# debug_host_driver

Host-side initiator for the pipeline debug UART protocol: drives the command byte stream a PC-side debugger would send (program load, run-to-halt, single step, end debug) into a UART TX FIFO, and parses the returned 65-word state frame (32 registers, 32 data-memory words, PC) from the UART RX FIFO into a dump port. It sits between a program ROM/test controller and a UART core, and is used for on-board self-test of the pipeline debugger without a PC.

## Interface
- ADDR_W, 8: program ROM address width; also the width of the program-size input.
- TIMEOUT, 1_000_000: maximum idle cycles between received bytes before abort.
- Reset is `i_reset`, asynchronous and active-high; the clock is `i_clk`.
- i_clk  in  1  clock
- i_reset  in  1  async active-high reset
- i_start  in  1  one-cycle command request; ignored while o_busy=1
- i_cmd  in  2  command: 00 LOAD, 01 RUN, 10 STEP, 11 END; sampled with i_start
- i_prog_size  in  ADDR_W  instruction count for LOAD; sampled with i_start
- o_rom_addr  out  ADDR_W  program ROM word address
- i_rom_data  in  32  ROM word; valid one cycle after o_rom_addr changes
- o_tx_data  out  8  byte to the TX FIFO
- o_wr  out  1  TX FIFO write strobe
- i_tx_full  in  1  TX FIFO full
- i_rx_data  in  8  RX FIFO head (show-ahead)
- o_rd  out  1  RX FIFO pop strobe
- i_rx_empty  in  1  RX FIFO empty
- o_dump_we  out  1  dump word write strobe
- o_dump_addr  out  7  dump index: 0-31 registers, 32-63 memory, 64 PC
- o_dump_data  out  32  assembled dump word
- o_busy  out  1  command in progress
- o_done  out  1  one-cycle completion pulse
- o_error  out  1  sticky timeout flag; cleared on accepted i_start
- o_session  out  1  debug (step) session open

## Operation
- States: IDLE, TX_CMD, TX_SIZE, ROM_FETCH, TX_INST, TX_NEXT, RX_FRAME, FINISH.
- Byte codes: LOAD 0xFE, RUN 0xF0, DEBUG 0xFC, NEXT 0x01, END 0xF8.
- IDLE: accept i_start, latch i_cmd and i_prog_size, clear o_error, go to TX_CMD.
- LOAD: send 0xFE, then the size byte (low 8 bits of i_prog_size). For k = 0..size-1: set o_rom_addr=k, ROM_FETCH for one cycle, then send the 4 bytes of i_rom_data LSB first. Then FINISH. A size of 0 goes directly to FINISH with no bytes sent.
- RUN: send 0xF0, then RX_FRAME; on completion, clear o_session.
- STEP: if o_session=0, send 0xFC and set o_session. Then send 0x01 (TX_NEXT), then RX_FRAME.
- END: if o_session=1, send 0xF8 and clear o_session. Otherwise go directly to FINISH.
- TX rule: o_wr=1 only when i_tx_full=0; at most one byte per cycle. When i_tx_full=1, hold the state and the byte.
- RX_FRAME: pop when i_rx_empty=0 (o_rd=1, byte taken from i_rx_data in the same cycle). Bytes are assembled LSB first. On each 4th byte, pulse o_dump_we the next cycle with o_dump_data/o_dump_addr; the index increments 0..64. After index 64 is written, go to FINISH. Total frame is 260 bytes.
- Timeout: a counter clears on every popped byte and on entry to RX_FRAME. If it reaches TIMEOUT in RX_FRAME, set o_error, clear o_session, and go to FINISH; the partial word is discarded.
- FINISH: pulse o_done for one cycle, return to IDLE. o_busy=1 in every state except IDLE.
- Reset mid-operation: return immediately to IDLE. The byte index, word index, session and error are cleared. No partial byte is written after reset.

## Timing
- Reset values: o_tx_data=0, o_wr=0, o_rd=0, o_rom_addr=0, o_dump_we=0, o_dump_addr=0, o_dump_data=0, o_busy=0, o_done=0, o_error=0, o_session=0.
- i_start accepted at edge N: o_busy=1 from N+1; first o_wr at N+1 if the FIFO is not full.
- LOAD with TX never full: 2 + 5·size cycles of activity (1 fetch + 4 writes per instruction), then o_done on the following cycle.
- ROM: address set in the cycle before TX_INST; data used without extra registering.
- Dump write: o_dump_we is one cycle after the 4th byte pop. Back-to-back pops are supported: a new byte may be popped in the same cycle o_dump_we is high.
- i_start asserted in the same cycle as o_done: ignored (o_busy still 1).

## Test plan
- LOAD, size 2, ROM {0x11223344, 0xAABBCCDD}, TX never full -> bytes FE 02 44 33 22 11 DD CC BB AA, one o_done, no o_rd.
- LOAD with i_tx_full toggling every other cycle -> identical byte sequence, no byte duplicated or dropped, o_wr never high while full.
- STEP twice, then END; responder returns a 260-byte frame with reg[i]=i, mem[i]=0x100+i, PC=0x40 -> TX: FC 01, 01, F8. 65 dump writes per step with correct addr/data; o_session 1 after the first STEP, 0 after END.
- RUN with RX bytes arriving with random gaps < TIMEOUT -> TX F0, 65 correct dump writes, o_done, o_error=0.
- RUN with the frame stopping after 100 bytes, TIMEOUT=64 -> o_error=1 after 64 idle cycles, o_done pulse, 25 dump writes only, o_session=0; the next i_start clears o_error.
- Async reset asserted mid-LOAD at the 3rd instruction -> all outputs at reset values; a new LOAD restarts with an FE header.
